convert_from_10: RTL and testbench
==================================

CONVERT_FROM_10 -- requirements
Module: convert_from_10

Interface
REQ-001 SHALL have parameter WIDTH, default 400, the binary result width in bits.
REQ-002 SHALL have parameter MAX_DIGITS, default 150, the maximum decimal digits accepted per conversion.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a conversion.
REQ-006 SHALL have port digit  input  4  decimal digit value, most significant digit first.
REQ-007 SHALL have port digit_valid  input  1  qualifies digit.
REQ-008 SHALL have port digit_last  input  1  marks the final digit; sampled with digit_valid.
REQ-009 SHALL have port digit_ready  output  1  block can accept a digit this cycle.
REQ-010 SHALL have port busy  output  1  high from start acceptance until done.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result is final.
REQ-012 SHALL have port binary  output  WIDTH  unsigned binary value of the digit string.
REQ-013 SHALL have port ndigits  output  8  count of digits accepted in the current or last conversion.
REQ-014 SHALL have port err  output  1  sticky; invalid digit or digit limit exceeded.
REQ-015 SHALL have port ovf  output  1  sticky; result exceeded 2^WIDTH-1.

Function
REQ-016 SHALL implement states IDLE, RUN, FIN.
REQ-017 SHALL, in IDLE on start=1: clear binary, ndigits, err and ovf, then enter RUN the next cycle.
REQ-018 SHALL ignore start in RUN and FIN.
REQ-019 SHALL drive digit_ready=1 only in RUN.
REQ-020 SHALL accept a digit on a cycle with digit_valid=1 and digit_ready=1; digits offered while ready=0 are not consumed.
REQ-021 SHALL, on acceptance of digit d<=9: binary <= (binary*10 + d) mod 2^WIDTH, computed as (binary<<3)+(binary<<1)+d; ndigits increments by 1.
REQ-022 SHALL set ovf when the exact value binary*10+d needs more than WIDTH bits, and SHALL continue accumulating modulo 2^WIDTH.
REQ-023 SHALL, on acceptance of digit d>9: leave binary and ndigits unchanged, set err, and enter FIN.
REQ-024 SHALL enter FIN after accepting a digit with digit_last=1.
REQ-025 SHALL, on accepting digit number MAX_DIGITS without digit_last: set err and enter FIN; this digit is still accumulated.
REQ-026 SHALL sustain one digit per cycle throughout RUN.
REQ-027 SHALL, in FIN: assert done for exactly one cycle, then return to IDLE.
REQ-028 SHALL have a latency of one cycle from the accepting edge of the last digit to done=1.
REQ-029 SHALL drive busy=1 in RUN and FIN, and 0 in IDLE.
REQ-030 SHALL hold binary, ndigits, err and ovf stable from done until the next accepted start.
REQ-031 SHALL accept start on the cycle immediately after done (back-to-back conversions).
REQ-032 SHALL treat leading zeros as valid digits; the value is unaffected and ndigits counts them.

Reset
REQ-033 SHALL, while rst=0, force state IDLE and binary=0, ndigits=0, err=0, ovf=0, done=0, busy=0, digit_ready=0, regardless of clk.
REQ-034 SHALL, on rst asserted mid-conversion, abandon the conversion without a done pulse; no partial result is preserved.
REQ-035 SHALL require a fresh start after rst deasserts before any digit is consumed.

Verification
REQ-036 SHALL pass: start; digits 1,2,3 with last on 3 -> done one cycle after 3; binary=123 (0x7B), ndigits=3, err=0, ovf=0.
REQ-037 SHALL pass: digits 2,7,1,8 with digit_valid gapped (valid low every other cycle) -> binary=2718 (0xA9E); gaps are not counted.
REQ-038 SHALL pass: digits 4,0xB,5 -> 0xB raises err and enters FIN; binary=4, ndigits=1, done pulses, and digit 5 is not consumed.
REQ-039 SHALL pass with WIDTH=8: digits 2,5,6 -> ovf=1, binary=0 (256 mod 256), err=0.
REQ-040 SHALL pass with MAX_DIGITS=4: five digits 9 offered, none last -> FIN after the 4th with err=1, binary=9999, ndigits=4.
REQ-041 SHALL pass: rst pulled low after 2 digits -> all outputs 0 with no done; after release, start plus digit 7 (last) gives binary=7.

Source files
------------

// File: rtl/convert_from_10.sv
`default_nettype none
// ============================================================================
//  Module   : convert_from_10
//  Purpose  : Streaming decimal-to-binary converter. Accepts a string of
//             decimal digits (most significant first, one per cycle) and
//             accumulates binary = binary*10 + digit, modulo 2^WIDTH.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       - width of the binary result in bits
//    MAX_DIGITS  - maximum number of digits accepted per conversion (1..255)
//  Ports
//    clk         in   1      single clock, rising edge
//    rst         in   1      asynchronous, active-low reset
//    start       in   1      one-cycle pulse, begins a conversion (IDLE only)
//    digit       in   4      decimal digit value, MSD first
//    digit_valid in   1      qualifies digit
//    digit_last  in   1      marks the final digit, sampled with digit_valid
//    digit_ready out  1      a digit can be accepted this cycle (RUN only)
//    busy        out  1      high in RUN and FIN
//    done        out  1      one-cycle pulse, result is final
//    binary      out  WIDTH  unsigned value of the digit string
//    ndigits     out  8      digits accepted in the current / last conversion
//    err         out  1      sticky: invalid digit or digit limit reached
//    ovf         out  1      sticky: value exceeded 2^WIDTH-1
// ============================================================================
module convert_from_10 #(
  parameter int WIDTH      = 400,
  parameter int MAX_DIGITS = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] binary,
  output logic [7:0]       ndigits,
  output logic             err,
  output logic             ovf
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_fin  = 2'd2;

  // ndigits value held *before* accepting the digit that reaches the limit
  localparam logic [7:0] c_last_idx = 8'(MAX_DIGITS - 1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] binary_q,  binary_d;
  logic [7:0]       ndigits_q, ndigits_d;
  logic             err_q,     err_d;
  logic             ovf_q,     ovf_d;

  // --------------------------------------------------------------------------
  // Multiply-by-ten accumulator
  //   The sum is formed four bits wider than the result so the exact value
  //   binary*10 + d (< 16 * 2^WIDTH) is available; any bit set above WIDTH
  //   means the true value no longer fits and ovf must be raised.
  // --------------------------------------------------------------------------
  logic [WIDTH+3:0] w_shl3;
  logic [WIDTH+3:0] w_shl1;
  logic [WIDTH+3:0] w_dext;
  logic [WIDTH+3:0] w_sum;
  logic             w_sum_ovf;
  logic             w_accept;
  logic             w_digit_bad;
  logic             w_at_limit;

  assign w_shl3    = {1'b0, binary_q, 3'b000};
  assign w_shl1    = {3'b000, binary_q, 1'b0};
  assign w_dext    = {{WIDTH{1'b0}}, digit};
  assign w_sum     = w_shl3 + w_shl1 + w_dext;
  assign w_sum_ovf = |w_sum[WIDTH+3:WIDTH];

  // A digit is consumed only while the block is presenting ready
  assign w_accept    = (state_q == c_st_run) && digit_valid;
  assign w_digit_bad = (digit > 4'd9);
  assign w_at_limit  = (ndigits_q == c_last_idx);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    binary_d  = binary_q;
    ndigits_d = ndigits_q;
    err_d     = err_q;
    ovf_d     = ovf_q;

    case (state_q)
      c_st_idle: begin
        // Results from the previous conversion are held until a new start
        if (start) begin
          binary_d  = '0;
          ndigits_d = '0;
          err_d     = 1'b0;
          ovf_d     = 1'b0;
          state_d   = c_st_run;
        end
      end

      c_st_run: begin
        if (w_accept) begin
          if (w_digit_bad) begin
            // Invalid digit: value and count are left untouched
            err_d   = 1'b1;
            state_d = c_st_fin;
          end else begin
            binary_d  = w_sum[WIDTH-1:0];
            ndigits_d = ndigits_q + 8'd1;
            if (w_sum_ovf) begin
              ovf_d = 1'b1;
            end
            if (digit_last) begin
              state_d = c_st_fin;
            end else if (w_at_limit) begin
              // Limit reached without a terminator: keep this digit, flag it
              err_d   = 1'b1;
              state_d = c_st_fin;
            end
          end
        end
      end

      c_st_fin: begin
        state_d = c_st_idle;
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= c_st_idle;
      binary_q  <= '0;
      ndigits_q <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      binary_q  <= binary_d;
      ndigits_q <= ndigits_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (status decoded straight from the state register so they drop
  // together with it when rst is asserted)
  // --------------------------------------------------------------------------
  assign digit_ready = (state_q == c_st_run);
  assign busy        = (state_q != c_st_idle);
  assign done        = (state_q == c_st_fin);
  assign binary      = binary_q;
  assign ndigits     = ndigits_q;
  assign err         = err_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_convert_from_10.sv
`default_nettype none
// ============================================================================
//  Module   : tb_convert_from_10
//  Purpose  : Self-checking bench for convert_from_10. Three instances:
//             default parameters, WIDTH=8 and MAX_DIGITS=4. Only the selected
//             instance sees start/digit_valid. Expected results are queued
//             when a conversion is launched and compared on done.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_convert_from_10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_last;
  int         sel;

  logic [2:0] start_g;
  logic [2:0] dv_g;
  assign start_g[0] = start && (sel == 0);
  assign start_g[1] = start && (sel == 1);
  assign start_g[2] = start && (sel == 2);
  assign dv_g[0]    = digit_valid && (sel == 0);
  assign dv_g[1]    = digit_valid && (sel == 1);
  assign dv_g[2]    = digit_valid && (sel == 2);

  logic [2:0]   rdy, bsy, dn, er, ov;
  logic [7:0]   nd0, nd1, nd2;
  logic [399:0] bin0, bin2;
  logic [7:0]   bin1;

  convert_from_10 u_dflt (
    .clk(clk), .rst(rst), .start(start_g[0]), .digit(digit),
    .digit_valid(dv_g[0]), .digit_last(digit_last), .digit_ready(rdy[0]),
    .busy(bsy[0]), .done(dn[0]), .binary(bin0), .ndigits(nd0),
    .err(er[0]), .ovf(ov[0])
  );

  convert_from_10 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_g[1]), .digit(digit),
    .digit_valid(dv_g[1]), .digit_last(digit_last), .digit_ready(rdy[1]),
    .busy(bsy[1]), .done(dn[1]), .binary(bin1), .ndigits(nd1),
    .err(er[1]), .ovf(ov[1])
  );

  convert_from_10 #(.MAX_DIGITS(4)) u_m4 (
    .clk(clk), .rst(rst), .start(start_g[2]), .digit(digit),
    .digit_valid(dv_g[2]), .digit_last(digit_last), .digit_ready(rdy[2]),
    .busy(bsy[2]), .done(dn[2]), .binary(bin2), .ndigits(nd2),
    .err(er[2]), .ovf(ov[2])
  );

  typedef struct {
    int          sel;
    int          n;
    logic [31:0] digs;   // digit i in bits [4i+3:4i], first digit at [3:0]
    bit          gap;
    logic [63:0] bin;
    int          nd;
    bit          err;
    bit          ovf;
  } vec_t;

  typedef struct {
    int          sel;
    logic [63:0] bin;
    int          nd;
    bit          err;
    bit          ovf;
  } exp_t;

  exp_t sbq[$];
  exp_t e_m;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] dn_prev = 3'b000;

  function automatic logic [63:0] lo(input int k);
    case (k)
      0:       return bin0[63:0];
      1:       return {56'd0, bin1};
      default: return bin2[63:0];
    endcase
  endfunction

  function automatic logic [63:0] ndk(input int k);
    case (k)
      0:       return {56'd0, nd0};
      1:       return {56'd0, nd1};
      default: return {56'd0, nd2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard checker: every done must match the oldest queued expectation
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dn[k]) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: dut %0d pulsed done with nothing expected", k);
        end else begin
          e_m = sbq.pop_front();
          chk("done_dut",     64'(k),        64'(e_m.sel));
          chk("binary",       lo(k),         e_m.bin);
          chk("ndigits",      ndk(k),        64'(e_m.nd));
          chk("err",          64'(er[k]),    64'(e_m.err));
          chk("ovf",          64'(ov[k]),    64'(e_m.ovf));
          chk("busy_at_done", 64'(bsy[k]),   64'd1);
          chk("done_single",  64'(dn_prev[k]), 64'd0);
        end
      end
    end
    dn_prev = dn;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int s);
    sel   = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic put(input logic [3:0] d, input bit l);
    digit       = d;
    digit_valid = 1'b1;
    digit_last  = l;
    cyc();
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic push(input int s, input logic [63:0] b, input int n, input bit e, input bit o);
    exp_t x;
    x.sel = s; x.bin = b; x.nd = n; x.err = e; x.ovf = o;
    sbq.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && sbq.size() != 0; i++) cyc();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected done pulse(s) never seen, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    push(v.sel, v.bin, v.nd, v.err, v.ovf);
    do_start(v.sel);
    for (int i = 0; i < v.n; i++) begin
      put(v.digs[4*i +: 4], (i == v.n - 1));
      if (v.gap) cyc();
    end
    // done cycle; the next start lands the cycle right after it
    cyc();
  endtask

  task automatic chk_zero(input string name, input int k);
    chk({name, "_bin"},   lo(k),        64'd0);
    chk({name, "_nd"},    ndk(k),       64'd0);
    chk({name, "_busy"},  64'(bsy[k]),  64'd0);
    chk({name, "_ready"}, 64'(rdy[k]),  64'd0);
    chk({name, "_done"},  64'(dn[k]),   64'd0);
    chk({name, "_err"},   64'(er[k]),   64'd0);
    chk({name, "_ovf"},   64'(ov[k]),   64'd0);
  endtask

  vec_t tv [10];

  initial begin
    start = 1'b0; digit = 4'd0; digit_valid = 1'b0; digit_last = 1'b0; sel = 0;

    // Reset: checked between clock edges, so it must act asynchronously
    #1 rst = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) chk_zero("reset", k);
    cyc(); cyc();
    rst = 1'b1;
    cyc();

    //        sel n  digits        gap  binary       nd err ovf
    tv[0] = '{0, 3, 32'h00000321, 1'b0, 64'd123,      3, 1'b0, 1'b0};
    tv[1] = '{0, 4, 32'h00008172, 1'b1, 64'd2718,     4, 1'b0, 1'b0};
    tv[2] = '{0, 4, 32'h00002400, 1'b0, 64'd42,       4, 1'b0, 1'b0};
    tv[3] = '{0, 8, 32'h99999999, 1'b0, 64'd99999999, 8, 1'b0, 1'b0};
    tv[4] = '{0, 5, 32'h00063556, 1'b0, 64'd65536,    5, 1'b0, 1'b0};
    tv[5] = '{0, 1, 32'h00000000, 1'b0, 64'd0,        1, 1'b0, 1'b0};
    tv[6] = '{1, 3, 32'h00000652, 1'b0, 64'd0,        3, 1'b0, 1'b1};
    tv[7] = '{1, 3, 32'h00000552, 1'b0, 64'd255,      3, 1'b0, 1'b0};
    tv[8] = '{1, 4, 32'h00001003, 1'b1, 64'd185,      4, 1'b0, 1'b1};
    tv[9] = '{2, 4, 32'h00004321, 1'b0, 64'd1234,     4, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) run_vec(tv[i]);
    wait_drain("table_drain");

    // 1,2,3 with a stray start mid-run; result then held after done
    push(0, 64'd123, 3, 1'b0, 1'b0);
    do_start(0);
    chk("busy_run",  64'(bsy[0]), 64'd1);
    chk("ready_run", 64'(rdy[0]), 64'd1);
    put(4'd1, 1'b0);
    start = 1'b1;
    put(4'd2, 1'b0);
    start = 1'b0;
    put(4'd3, 1'b1);
    cyc(); cyc(); cyc();
    wait_drain("hold_drain");
    chk("hold_binary", lo(0),       64'd123);
    chk("hold_nd",     ndk(0),      64'd3);
    chk("idle_busy",   64'(bsy[0]), 64'd0);
    chk("idle_ready",  64'(rdy[0]), 64'd0);

    // Invalid digit: 4, 0xB, then 5 offered but must not be consumed
    push(0, 64'd4, 1, 1'b1, 1'b0);
    do_start(0);
    put(4'd4, 1'b0);
    put(4'hB, 1'b0);
    chk("ready_fin", 64'(rdy[0]), 64'd0);
    digit = 4'd5; digit_valid = 1'b1;
    cyc(); cyc(); cyc();
    digit_valid = 1'b0;
    wait_drain("baddigit_drain");
    chk("baddigit_bin", lo(0),      64'd4);
    chk("baddigit_nd",  ndk(0),     64'd1);
    chk("baddigit_err", 64'(er[0]), 64'd1);

    // Digit limit of 4: five 9s offered, none marked last
    push(2, 64'd9999, 4, 1'b1, 1'b0);
    do_start(2);
    for (int i = 0; i < 5; i++) put(4'd9, 1'b0);
    wait_drain("limit_drain");
    chk("limit_nd",  ndk(2), 64'd4);
    chk("limit_bin", lo(2),  64'd9999);

    // Reset mid-conversion, then a fresh start is needed
    do_start(0);
    put(4'd3, 1'b0);
    put(4'd8, 1'b0);
    #2 rst = 1'b0;
    #1 chk_zero("midrst", 0);
    cyc(); cyc();
    rst = 1'b1;
    digit = 4'd7; digit_valid = 1'b1; digit_last = 1'b1;
    cyc(); cyc();
    digit_valid = 1'b0; digit_last = 1'b0;
    chk("nostart_nd",   ndk(0),      64'd0);
    chk("nostart_busy", 64'(bsy[0]), 64'd0);
    push(0, 64'd7, 1, 1'b0, 1'b0);
    do_start(0);
    put(4'd7, 1'b1);
    cyc();
    wait_drain("postrst_drain");

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
